// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits MSB first, optional parity, 1-2 stop bits; tx falls one cycle after accept.
// One-deep hold register; tx_ready low while it is full, so a second byte can queue behind the frame on the line.
module uart_tx #(
    parameter int CLKS_PER_BIT = 27,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk_3125,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [7:0] LAST_CNT  = 8'(CLKS_PER_BIT - 1);
    localparam logic       LAST_STOP = (STOP_BITS == 2);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [2:0] bit_idx, bit_idx_nxt, bit_idx_m1;
    logic       stop_idx, stop_idx_nxt;
    logic [7:0] shift, hold;
    logic       hold_full;
    logic       load;
    logic       tx_nxt, done_nxt;
    logic       bit_end, par_bit;

    assign bit_end    = (cnt == LAST_CNT);
    assign bit_idx_m1 = bit_idx - 3'd1;
    // Parity comes from the latched byte so tx_data may change after accept.
    assign par_bit    = (PARITY_ODD != 0) ? ~^shift : ^shift;
    assign tx_ready   = ~hold_full;
    assign tx_busy    = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = bit_end ? 8'd0 : cnt + 8'd1;
        bit_idx_nxt  = bit_idx;
        stop_idx_nxt = stop_idx;
        tx_nxt       = tx;
        done_nxt     = 1'b0;
        load         = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = 8'd0;
                tx_nxt  = 1'b1;
                if (hold_full) begin
                    load      = 1'b1;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = 3'd7;
                    tx_nxt      = shift[7];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx != 3'd0) begin
                        bit_idx_nxt = bit_idx_m1;
                        tx_nxt      = shift[bit_idx_m1];
                    end else if (PARITY_EN != 0) begin
                        state_nxt = PARITY;
                        tx_nxt    = par_bit;
                    end else begin
                        state_nxt    = STOP;
                        stop_idx_nxt = 1'b0;
                        tx_nxt       = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt    = STOP;
                    stop_idx_nxt = 1'b0;
                    tx_nxt       = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_idx == LAST_STOP) begin
                        done_nxt = 1'b1;
                        // A queued byte chains straight into the next start bit.
                        if (hold_full) begin
                            load      = 1'b1;
                            state_nxt = START;
                            tx_nxt    = 1'b0;
                        end else begin
                            state_nxt = IDLE;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        stop_idx_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_3125 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            bit_idx   <= 3'd0;
            stop_idx  <= 1'b0;
            shift     <= 8'd0;
            hold      <= 8'd0;
            hold_full <= 1'b0;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            stop_idx <= stop_idx_nxt;
            tx       <= tx_nxt;
            tx_done  <= done_nxt;
            if (load) begin
                shift <= hold;
            end
            if (tx_start && !hold_full) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule
